// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
//   Bit-serial, LSB-first subtractor. It computes a - b one bit per clock
//   using a single full-subtractor cell and a borrow flop. The result is
//   available N clock cycles after the start request is accepted.
//
//   Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output.
//   ovf flags a signed two's-complement overflow and is held with diff.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request a new operation; only sampled in IDLE or DONE
//   a, b        minuend and subtrahend, captured when start is accepted
//   busy        high while the operand bits are being shifted through
//   done        one-cycle pulse; diff and borrow_out are fresh this cycle
//   diff        (a - b) mod 2^N, held until the next completion
//   borrow_out  unsigned underflow (a < b), held with diff
//   ovf         (SERIAL_SUBTRACTOR_OVF_EN only) signed overflow, held with diff

module serial_subtractor_4bit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [N-1:0]  a_sh_reg;
  logic [N-1:0]  b_sh_reg;
  // Only the upper N-1 result bits need storage: the final bit is combined
  // directly into diff on the completion edge.
  logic [N-2:0]  r_sh_reg;
  logic          brw_reg;
  logic [CW-1:0] cnt_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic          a_msb_reg;
  logic          b_msb_reg;
`endif

  logic          d_bit;
  logic          brw_next;
  logic [N-1:0]  r_next;
  logic          accept;
  logic          last_bit;

  // Full-subtractor cell on the current LSBs.
  assign d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ brw_reg;
  assign brw_next = (~a_sh_reg[0] & b_sh_reg[0]) |
                    (~(a_sh_reg[0] ^ b_sh_reg[0]) & brw_reg);

  // New bit enters at the MSB, so after N shifts the result is LSB-aligned.
  assign r_next   = {d_bit, r_sh_reg};

  assign accept   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign last_bit = (state_reg == S_SHIFT) && (cnt_reg == CW'(N - 1));

  // Next-state and outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt_reg == CW'(N - 1)) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_next = start ? S_SHIFT : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      r_sh_reg   <= '0;
      brw_reg    <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      r_sh_reg  <= '0;
      brw_reg   <= 1'b0;
      cnt_reg   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      // The shift registers lose the sign bits, so keep them for ovf.
      a_msb_reg <= a[N-1];
      b_msb_reg <= b[N-1];
`endif
    end else if (state_reg == S_SHIFT) begin
      a_sh_reg <= a_sh_reg >> 1;
      b_sh_reg <= b_sh_reg >> 1;
      brw_reg  <= brw_next;
      r_sh_reg <= r_next[N-1:1];
      cnt_reg  <= cnt_reg + CW'(1);
      if (last_bit) begin
        diff       <= r_next;
        borrow_out <= brw_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        // d_bit is the result MSB on the last shift.
        ovf        <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Testbench for serial_subtractor_4bit (N = 4). Directed vectors with
// hand-computed results are pushed into a scoreboard when issued; a monitor
// pops and compares on every done pulse and checks held outputs otherwise.

module tb_serial_subtractor_4bit;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  serial_subtractor_4bit #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         brw;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   ops_seen = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare results on done, otherwise outputs must hold.
  initial begin : monitor
    exp_t       e;
    exp_t       held;
    int         busy_cnt;
    logic       ov_act;
    held     = '0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ov_act = ovf;
`else
      ov_act = 1'b0;
`endif
      if (!rst_n) begin
        held     = '0;
        busy_cnt = 0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_borrow", int'(borrow_out), 0);
        check("reset_ovf", int'(ov_act), 0);
      end else if (done) begin
        ops_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("diff", int'(diff), int'(e.d));
          check("borrow_out", int'(borrow_out), int'(e.brw));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          check("ovf", int'(ov_act), int'(e.ov));
`endif
          check("busy_cycles", busy_cnt, N);
          held = e;
        end
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (diff != held.d || borrow_out != held.brw) begin
          checks++;
          fails++;
          $display("FAIL held_result: got diff=%0d brw=%0d, expected diff=%0d brw=%0d (t=%0t)",
                   diff, borrow_out, held.d, held.brw, $time);
        end
      end
    end
  end

  // Drive a request once the DUT is ready; returns one negedge later with start low.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] ed, input logic eb, input logic eo,
                       input bit push);
    int w;
    exp_t e;
    w = 0;
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("ready_timeout", 1, 0);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.d   = ed;
      e.brw = eb;
      e.ov  = eo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!done) check("done_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N-1:0] ed, input logic eb, input logic eo);
    issue(av, bv, ed, eb, eo, 1'b1);
    wait_done();
    @(negedge clk); // one IDLE cycle between operations
  endtask

  initial begin : stim
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("init_busy", int'(busy), 0);
    check("init_diff", int'(diff), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    //      a      b      diff   brw   ovf
    run_op(4'd0,  4'd4,  4'd12, 1'b1, 1'b0);
    run_op(4'd9,  4'd7,  4'd2,  1'b0, 1'b1);
    run_op(4'd15, 4'd15, 4'd0,  1'b0, 1'b0);

    // Second start while busy must be ignored.
    issue(4'd5, 4'd3, 4'd2, 1'b0, 1'b0, 1'b1);
    check("busy_after_accept", int'(busy), 1);
    a     = 4'd1;
    b     = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back: start held during the DONE cycle.
    issue(4'd6, 4'd9, 4'd13, 1'b1, 1'b1, 1'b1);
    check("b2b_no_idle_busy", int'(busy), 1);
    wait_done();
    @(negedge clk);

    // Reset in mid-operation: outputs clear at once, no done follows.
    issue(4'd12, 4'd3, 4'd9, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_borrow", int'(borrow_out), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);

    run_op(4'd10, 4'd3, 4'd7,  1'b0, 1'b1);
    run_op(4'd8,  4'd1, 4'd7,  1'b0, 1'b1);
    run_op(4'd7,  4'd8, 4'd15, 1'b1, 1'b1);
    run_op(4'd3,  4'd5, 4'd14, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    check("pending_ops", exp_q.size(), 0);
    check("done_pulses", ops_seen, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
